serial_deser: RTL and testbench

SERIAL_DESER -- requirements
Module: serial_deser

---
 rtl/serial_deser_pkg.sv | 12 +
 rtl/serial_deser_sipo_shift.sv | 51 +++++
 rtl/serial_deser.sv | 84 ++++++++
 tb/tb_serial_deser.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/serial_deser_pkg.sv
// Shared types and constants for the serial-to-parallel deserializer.
// Imported by the shift/count stage and by the output stage.
package serial_deser_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage : serial_deser_pkg

// File: rtl/serial_deser_sipo_shift.sv
// MSB-first serial-in/parallel-out shift register with a per-word bit counter.
// Only the first WIDTH-1 bits are stored; the last bit is taken directly from bit_in.
module sipo_shift
    import serial_deser_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] data,
    output logic [CW-1:0]    count,
    output logic             done
);

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [WIDTH-2:0] shift_q, shift_d;
    logic [CW-1:0]    count_q, count_d;
    logic             last_bit;

    // data is only meaningful in the cycle where done=1.
    assign data     = {shift_q, bit_in};
    assign last_bit = (count_q == LAST_IDX);
    assign done     = bit_valid && last_bit;
    assign count    = count_q;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        shift_d = shift_q;
        count_d = count_q;
        if (bit_valid) begin
            shift_d = data[WIDTH-2:0];
            count_d = last_bit ? '0 : count_q + CW'(1);
        end
    end

    // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            count_q <= '0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

endmodule : sipo_shift

// File: rtl/serial_deser.sv
// Serial-to-parallel deserializer: collects WIDTH bits MSB-first and presents
// them as a held word with a valid/ready handshake and a sticky drop flag.
module serial_deser
    import serial_deser_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overflow,
    output logic [CW-1:0]    bit_count
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH-1:0] sipo_data;
    logic             sipo_done;
    logic             handshake;

    sipo_shift #(
        .WIDTH(WIDTH)
    ) u_sipo (
        .clk      (clk),
        .reset    (reset),
        .bit_in   (bit_in),
        .bit_valid(bit_valid),
        .data     (sipo_data),
        .count    (bit_count),
        .done     (sipo_done)
    );

    assign word_valid = (state_q == FULL);
    assign handshake  = word_valid && word_ready;

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        overflow_d = overflow_q;
        case (state_q)
            EMPTY: begin
                if (sipo_done) begin
                    word_d  = sipo_data;
                    state_d = FULL;
                end
            end
            FULL: begin
                // A word completing while the held one is consumed replaces it
                // seamlessly; completing while it is still held drops the new one.
                if (handshake && sipo_done) begin
                    word_d = sipo_data;
                end else if (handshake) begin
                    state_d = EMPTY;
                end else if (sipo_done) begin
                    overflow_d = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            word_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            overflow_q <= overflow_d;
        end
    end

    assign word_out = word_q;
    assign overflow = overflow_q;

endmodule : serial_deser

// File: tb/tb_serial_deser.sv
// Directed self-checking bench for serial_deser (WIDTH=8) with a word scoreboard.
module tb_serial_deser;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH);

    logic             clk;
    logic             reset;
    logic             bit_in;
    logic             bit_valid;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic             overflow;
    logic [CW-1:0]    bit_count;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] exp_q[$];

    serial_deser #(
        .WIDTH(WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .word_out  (word_out),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .overflow  (overflow),
        .bit_count (bit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are observed there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w);
        for (int i = WIDTH - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    // Scoreboard: every accepted handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset && word_valid === 1'b1 && word_ready === 1'b1) begin
            check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("sb_word", 32'(word_out), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [WIDTH-1:0] w;

        reset      = 1'b1;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        word_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_word", 32'(word_out), 32'd0);
        check("rst_count", 32'(bit_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // Back-to-back bits with the consumer always ready.
        word_ready = 1'b1;
        w = 8'hB2;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i == 0) exp_q.push_back(w);
            send_bit(w[i]);
            if (i == 4) check("b2b_count4", 32'(bit_count), 32'd4);
        end
        check("b2b_valid", 32'(word_valid), 32'd1);
        check("b2b_word", 32'(word_out), 32'hB2);
        check("b2b_count_wrap", 32'(bit_count), 32'd0);
        check("b2b_overflow", 32'(overflow), 32'd0);
        tick();
        check("b2b_valid_one_cycle", 32'(word_valid), 32'd0);

        // Same word with idle gaps of 1-3 cycles; the counter must hold during gaps.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i == 0) exp_q.push_back(w);
            send_bit(w[i]);
            if (i != 0) begin
                for (int g = 0; g <= (i % 3); g++) tick();
                check("gap_count_frozen", 32'(bit_count), 32'(WIDTH - i));
                check("gap_no_valid", 32'(word_valid), 32'd0);
            end
        end
        check("gap_valid", 32'(word_valid), 32'd1);
        check("gap_word", 32'(word_out), 32'hB2);
        tick();

        // Consumer stalled: the second word is dropped and overflow sticks.
        word_ready = 1'b0;
        exp_q.push_back(8'hB2);
        send_word(8'hB2);
        check("ovf_first_valid", 32'(word_valid), 32'd1);
        check("ovf_first_clear", 32'(overflow), 32'd0);
        send_word(8'h5A);
        check("ovf_word_held", 32'(word_out), 32'hB2);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_still_valid", 32'(word_valid), 32'd1);
        check("ovf_count_running", 32'(bit_count), 32'd0);
        word_ready = 1'b1;
        tick();
        check("ovf_drain_valid", 32'(word_valid), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ovf_word_kept", 32'(word_out), 32'hB2);

        // Handshake on the same edge that the next word completes.
        reset = 1'b1;
        tick();
        reset      = 1'b0;
        word_ready = 1'b0;
        check("ovf_cleared_by_reset", 32'(overflow), 32'd0);
        exp_q.push_back(8'hB2);
        send_word(8'hB2);
        w = 8'h5A;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i == 0) begin
                word_ready = 1'b1;
                exp_q.push_back(w);
            end
            send_bit(w[i]);
        end
        check("swap_word", 32'(word_out), 32'h5A);
        check("swap_valid", 32'(word_valid), 32'd1);
        check("swap_overflow", 32'(overflow), 32'd0);
        tick();
        check("swap_drained", 32'(word_valid), 32'd0);

        // Reset mid-word, with bit_valid asserted during reset, discards the partial word.
        for (int i = 0; i < 5; i++) send_bit(1'(i % 2 == 0));
        check("partial_count", 32'(bit_count), 32'd5);
        reset     = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        reset     = 1'b0;
        bit_valid = 1'b0;
        check("mid_rst_count", 32'(bit_count), 32'd0);
        check("mid_rst_valid", 32'(word_valid), 32'd0);
        check("mid_rst_word", 32'(word_out), 32'd0);
        w = 8'hFF;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i == 0) exp_q.push_back(w);
            send_bit(w[i]);
            if (i == 1) check("post_rst_count7", 32'(bit_count), 32'd7);
        end
        check("post_rst_word", 32'(word_out), 32'hFF);
        check("post_rst_valid", 32'(word_valid), 32'd1);
        tick();
        tick();

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_deser
